// File: rtl/conv_pkg.sv
// Shared types and the kernel table for the KxK RGB565 convolution.
// Kernels are stored as 5x5. A 3x3 window uses the centre 3x3 of each
// entry, and the shift values are the same for both window sizes.
package conv_pkg;

   // Number of entries in the kernel table below.
   localparam int N_KERNEL_TABLE = 4;
   // Largest supported window; table entries are stored at this size.
   localparam int KMAX           = 5;
   // Accumulator width; 25 taps of 8-bit signed x 6-bit unsigned fit easily.
   localparam int ACC_W          = 20;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   typedef logic signed [7:0] coef_t;

   localparam coef_t CZ  = 8'sd0;
   localparam coef_t CP1 = 8'sd1;
   localparam coef_t CP2 = 8'sd2;
   localparam coef_t CP4 = 8'sd4;
   localparam coef_t CP5 = 8'sd5;
   localparam coef_t CP8 = 8'sd8;
   localparam coef_t CM1 = -8'sd1;

   // Indexed [kernel][row][col]. All kernels are zero outside the centre 3x3.
   localparam coef_t KERNELS [N_KERNEL_TABLE][KMAX][KMAX] = '{
      // 0: identity
      '{ '{CZ, CZ,  CZ,  CZ,  CZ},
         '{CZ, CZ,  CZ,  CZ,  CZ},
         '{CZ, CZ,  CP1, CZ,  CZ},
         '{CZ, CZ,  CZ,  CZ,  CZ},
         '{CZ, CZ,  CZ,  CZ,  CZ} },
      // 1: gaussian, outer product of 1-2-1 (gain 16)
      '{ '{CZ, CZ,  CZ,  CZ,  CZ},
         '{CZ, CP1, CP2, CP1, CZ},
         '{CZ, CP2, CP4, CP2, CZ},
         '{CZ, CP1, CP2, CP1, CZ},
         '{CZ, CZ,  CZ,  CZ,  CZ} },
      // 2: sharpen, centre 5 with orthogonal -1
      '{ '{CZ, CZ,  CZ,  CZ,  CZ},
         '{CZ, CZ,  CM1, CZ,  CZ},
         '{CZ, CM1, CP5, CM1, CZ},
         '{CZ, CZ,  CM1, CZ,  CZ},
         '{CZ, CZ,  CZ,  CZ,  CZ} },
      // 3: edge, centre 8 with the 8-neighbour ring at -1
      '{ '{CZ, CZ,  CZ,  CZ,  CZ},
         '{CZ, CM1, CM1, CM1, CZ},
         '{CZ, CM1, CP8, CM1, CZ},
         '{CZ, CM1, CM1, CM1, CZ},
         '{CZ, CZ,  CZ,  CZ,  CZ} }
   };

   // Arithmetic right shift applied after accumulation, per kernel.
   localparam logic [2:0] SHIFTS [N_KERNEL_TABLE] = '{3'd0, 3'd4, 3'd0, 3'd0};

endpackage

// File: rtl/conv_channel_mac.sv
// One colour channel of the convolution: KxK signed multiply-accumulate
// (stage 2), then arithmetic shift and clamp to [0, 2^W-1] (stage 3).
module conv_channel_mac
   import conv_pkg::*;
#(
   parameter int K = 3,
   parameter int W = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [K*K-1:0][W-1:0]  pix,
   input  logic [K*K-1:0][7:0]    coef,
   input  logic [2:0]             shift,
   output logic [W-1:0]           result
);

   localparam int TAPS = K * K;
   localparam logic signed [ACC_W-1:0] MAX_VAL = {{(ACC_W-W){1'b0}}, {W{1'b1}}};

   logic signed [ACC_W-1:0] sum_comb;
   logic signed [ACC_W-1:0] sum_q;
   logic [2:0]              shift_q;
   logic signed [ACC_W-1:0] shifted;
   logic [W-1:0]            clamped;

   // Sum of coef*pix; coefficients sign-extended, pixels zero-extended.
   always_comb begin
      logic signed [ACC_W-1:0] c_ext;
      logic signed [ACC_W-1:0] p_ext;
      sum_comb = '0;
      c_ext    = '0;
      p_ext    = '0;
      for (int i = 0; i < TAPS; i++) begin
         c_ext    = {{(ACC_W-8){coef[i][7]}}, coef[i]};
         p_ext    = {{(ACC_W-W){1'b0}}, pix[i]};
         sum_comb = sum_comb + c_ext * p_ext;
      end
   end

   // Stage 2 register: full-precision sum and the shift that goes with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q   <= '0;
         shift_q <= '0;
      end else begin
         sum_q   <= sum_comb;
         shift_q <= shift;
      end
   end

   // Scale down, then saturate negatives to 0 and overflow to full scale.
   always_comb begin
      shifted = sum_q >>> shift_q;
      if (shifted[ACC_W-1]) begin
         clamped = '0;
      end else if (shifted > MAX_VAL) begin
         clamped = '1;
      end else begin
         clamped = shifted[W-1:0];
      end
   end

   // Stage 3 register: the channel's output value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
      end else begin
         result <= clamped;
      end
   end

endmodule

// File: rtl/convolution_kxk.sv
// KxK sliding-window RGB565 convolution with a run-time selectable kernel.
// Interface semantics: data_valid_in qualifies data_in/hcount_in/vcount_in
// in the cycle it is high; there is no backpressure. The pipeline runs every
// cycle and data_valid_out marks the slots that carry a real pixel, exactly
// LATENCY cycles after the matching input.
module convolution_kxk
   import conv_pkg::*;
#(
   parameter int K           = 3,
   parameter int NUM_KERNELS = 4
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic [K-1:0][15:0]             data_in,
   input  logic [10:0]                    hcount_in,
   input  logic [9:0]                     vcount_in,
   input  logic                           data_valid_in,
   input  logic [$clog2(NUM_KERNELS)-1:0] kernel_sel_in,
   output logic [15:0]                    line_out,
   output logic [10:0]                    hcount_out,
   output logic [9:0]                     vcount_out,
   output logic                           data_valid_out,
   output logic [$clog2(NUM_KERNELS)-1:0] kernel_active_out
);

   localparam int LATENCY = 3;
   localparam int KSEL_W  = $clog2(NUM_KERNELS);
   localparam int OFF     = (KMAX - K) / 2;
   localparam int TAPS    = K * K;

   if (K != 3 && K != 5) begin : g_bad_k
      $error("convolution_kxk: K must be 3 or 5");
   end
   if (NUM_KERNELS != N_KERNEL_TABLE) begin : g_bad_nk
      $error("convolution_kxk: NUM_KERNELS must match the package kernel table");
   end

   // Window: win[col][row]; col 0 is the oldest column, K-1 the newest.
   logic [K-1:0][15:0] win      [K];
   logic [K-1:0][15:0] win_next [K];

   logic [KSEL_W-1:0]  kernel_active;
   logic [KSEL_W-1:0]  kernel_next;
   logic               frame_start;

   logic [TAPS-1:0][7:0] s1_coef;
   logic [2:0]           s1_shift;

   logic [TAPS-1:0][4:0] pix_r;
   logic [TAPS-1:0][5:0] pix_g;
   logic [TAPS-1:0][4:0] pix_b;
   logic [4:0]           res_r;
   logic [5:0]           res_g;
   logic [4:0]           res_b;

   logic                 valid_pipe  [LATENCY];
   logic [10:0]          hcount_pipe [LATENCY];
   logic [9:0]           vcount_pipe [LATENCY];

   assign frame_start = data_valid_in && (hcount_in == '0) && (vcount_in == '0);

   // Kernel choice is only honoured on the first valid pixel of a frame.
   always_comb begin
      kernel_next = kernel_active;
      if (frame_start) begin
         if (int'(kernel_sel_in) < NUM_KERNELS) begin
            kernel_next = kernel_sel_in;
         end else begin
            kernel_next = '0;
         end
      end
   end

   // Next window: replicate at the left edge, shift on other valid pixels.
   always_comb begin
      for (int c = 0; c < K; c++) begin
         win_next[c] = win[c];
      end
      if (data_valid_in) begin
         if (hcount_in == '0) begin
            for (int c = 0; c < K; c++) begin
               win_next[c] = data_in;
            end
         end else begin
            for (int c = 0; c < K - 1; c++) begin
               win_next[c] = win[c + 1];
            end
            win_next[K-1] = data_in;
         end
      end
   end

   // Stage 1 window register; holds its value across invalid cycles.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int c = 0; c < K; c++) begin
            win[c] <= '0;
         end
      end else begin
         for (int c = 0; c < K; c++) begin
            win[c] <= win_next[c];
         end
      end
   end

   // Active kernel index, visible on kernel_active_out.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         kernel_active <= '0;
      end else begin
         kernel_active <= kernel_next;
      end
   end

   // Stage 1 coefficients: centre KxK of the chosen kernel, plus its shift.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s1_coef  <= '0;
         s1_shift <= '0;
      end else begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               s1_coef[r*K + c] <= KERNELS[kernel_next][r + OFF][c + OFF];
            end
         end
         s1_shift <= SHIFTS[kernel_next];
      end
   end

   // Split each window pixel into its channels, tap index = row*K + col.
   for (genvar r = 0; r < K; r++) begin : g_row
      for (genvar c = 0; c < K; c++) begin : g_col
         rgb565_t px;
         assign px                = win[c][r];
         assign pix_r[r*K + c]    = px.r;
         assign pix_g[r*K + c]    = px.g;
         assign pix_b[r*K + c]    = px.b;
      end
   end

   conv_channel_mac #(.K(K), .W(5)) u_mac_r (
      .clk    (clk_in),
      .rst    (rst_in),
      .pix    (pix_r),
      .coef   (s1_coef),
      .shift  (s1_shift),
      .result (res_r)
   );

   conv_channel_mac #(.K(K), .W(6)) u_mac_g (
      .clk    (clk_in),
      .rst    (rst_in),
      .pix    (pix_g),
      .coef   (s1_coef),
      .shift  (s1_shift),
      .result (res_g)
   );

   conv_channel_mac #(.K(K), .W(5)) u_mac_b (
      .clk    (clk_in),
      .rst    (rst_in),
      .pix    (pix_b),
      .coef   (s1_coef),
      .shift  (s1_shift),
      .result (res_b)
   );

   // Sideband delay line matching the three data stages.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < LATENCY; i++) begin
            valid_pipe[i]  <= 1'b0;
            hcount_pipe[i] <= '0;
            vcount_pipe[i] <= '0;
         end
      end else begin
         valid_pipe[0]  <= data_valid_in;
         hcount_pipe[0] <= hcount_in;
         vcount_pipe[0] <= vcount_in;
         for (int i = 1; i < LATENCY; i++) begin
            valid_pipe[i]  <= valid_pipe[i-1];
            hcount_pipe[i] <= hcount_pipe[i-1];
            vcount_pipe[i] <= vcount_pipe[i-1];
         end
      end
   end

   assign line_out          = {res_r, res_g, res_b};
   assign hcount_out        = hcount_pipe[LATENCY-1];
   assign vcount_out        = vcount_pipe[LATENCY-1];
   assign data_valid_out    = valid_pipe[LATENCY-1];
   assign kernel_active_out = kernel_active;

endmodule

// File: tb/tb_convolution_kxk.sv
// Bench for convolution_kxk (K=3): directed columns with hand-computed
// expected pixels pushed into a queue, checked by an independent monitor.
`timescale 1ns/100ps
module tb_convolution_kxk;

   localparam int K     = 3;
   localparam int EXP_W = 53;  // {issue cycle[15:0], line[15:0], hcount[10:0], vcount[9:0]}

   logic              clk_in = 1'b0;
   logic              rst_in;
   logic [K-1:0][15:0] data_in;
   logic [10:0]       hcount_in;
   logic [9:0]        vcount_in;
   logic              data_valid_in;
   logic [1:0]        kernel_sel_in;
   logic [15:0]       line_out;
   logic [10:0]       hcount_out;
   logic [9:0]        vcount_out;
   logic              data_valid_out;
   logic [1:0]        kernel_active_out;

   logic [EXP_W-1:0]  exp_q[$];
   logic [EXP_W-1:0]  mon_e;
   logic [15:0]       mon_lat;
   int                checks = 0;
   int                errors = 0;
   int                cyc    = 0;
   int                found;

   convolution_kxk #(.K(K), .NUM_KERNELS(4)) dut (
      .clk_in            (clk_in),
      .rst_in            (rst_in),
      .data_in           (data_in),
      .hcount_in         (hcount_in),
      .vcount_in         (vcount_in),
      .data_valid_in     (data_valid_in),
      .kernel_sel_in     (kernel_sel_in),
      .line_out          (line_out),
      .hcount_out        (hcount_out),
      .vcount_out        (vcount_out),
      .data_valid_out    (data_valid_out),
      .kernel_active_out (kernel_active_out)
   );

   // Clock and cycle counter
   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Present one column; valid columns push their expected filtered pixel.
   task automatic drive(input logic [15:0] top, input logic [15:0] mid, input logic [15:0] bot,
                        input int h, input int v, input logic valid, input logic [1:0] sel,
                        input logic [15:0] exp_line);
      @(posedge clk_in);
      #1;
      data_in[0]    = top;
      data_in[1]    = mid;
      data_in[2]    = bot;
      hcount_in     = h[10:0];
      vcount_in     = v[9:0];
      data_valid_in = valid;
      kernel_sel_in = sel;
      if (valid) exp_q.push_back({cyc[15:0], exp_line, h[10:0], v[9:0]});
   endtask

   task automatic idle();
      drive(16'h0000, 16'h0000, 16'h0000, 0, 0, 1'b0, 2'd0, 16'h0000);
   endtask

   // Monitor: every valid output must match the oldest expectation, 3 cycles late.
   always @(negedge clk_in) begin
      if (data_valid_out === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output line=%h hcount=%0d vcount=%0d", line_out, hcount_out, vcount_out);
         end else begin
            mon_e   = exp_q.pop_front();
            mon_lat = cyc[15:0] - mon_e[52:37];
            if (line_out !== mon_e[36:21] || hcount_out !== mon_e[20:10] ||
                vcount_out !== mon_e[9:0] || mon_lat != 16'd3) begin
               errors++;
               $display("FAIL pixel got line=%h hcount=%0d vcount=%0d latency=%0d, want line=%h hcount=%0d vcount=%0d latency=3",
                        line_out, hcount_out, vcount_out, mon_lat, mon_e[36:21], mon_e[20:10], mon_e[9:0]);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_in        = 1'b1;
      data_in       = '0;
      hcount_in     = '0;
      vcount_in     = '0;
      data_valid_in = 1'b0;
      kernel_sel_in = '0;
      repeat (2) @(posedge clk_in);
      #1;
      check("reset_line", line_out, 0);
      check("reset_valid", data_valid_out, 0);
      check("reset_hcount", hcount_out, 0);
      check("reset_vcount", vcount_out, 0);
      check("reset_kernel", kernel_active_out, 0);
      #2 rst_in = 1'b0;

      // Identity: output is the centre of the window, one column behind.
      drive(16'hFFFF, 16'h0841, 16'hFFFF, 0, 0, 1'b1, 2'd0, 16'h0841);
      drive(16'h0000, 16'h1082, 16'h0000, 1, 0, 1'b1, 2'd0, 16'h0841);
      drive(16'hAAAA, 16'h18C3, 16'h5555, 2, 0, 1'b1, 2'd0, 16'h1082);
      drive(16'h1234, 16'h2104, 16'h4321, 3, 0, 1'b1, 2'd0, 16'h18C3);
      // Kernel request mid-frame is ignored.
      drive(16'h1111, 16'h4321, 16'h2222, 0, 5, 1'b1, 2'd1, 16'h4321);
      drive(16'h0000, 16'h0000, 16'h0000, 1, 5, 1'b1, 2'd1, 16'h4321);
      idle();
      check("kernel_hold_midframe", kernel_active_out, 0);

      // Gaussian flat field {16,32,16}: no ramp at the left edge.
      drive(16'h8410, 16'h8410, 16'h8410, 0, 0, 1'b1, 2'd1, 16'h8410);
      idle();
      check("kernel_latch_frame_start", kernel_active_out, 1);
      drive(16'h8410, 16'h8410, 16'h8410, 1, 0, 1'b1, 2'd1, 16'h8410);
      drive(16'h8410, 16'h8410, 16'h8410, 2, 0, 1'b1, 2'd1, 16'h8410);
      drive(16'h8410, 16'h8410, 16'h8410, 3, 0, 1'b1, 2'd1, 16'h8410);
      drive(16'h8410, 16'h8410, 16'h8410, 0, 1, 1'b1, 2'd0, 16'h8410);
      drive(16'h8410, 16'h8410, 16'h8410, 1, 1, 1'b1, 2'd0, 16'h8410);
      idle();
      check("kernel_hold_next_line", kernel_active_out, 1);

      // Sharpen: saturation high, saturation low, and an unclamped 5x case.
      drive(16'h0000, 16'h0000, 16'h0000, 0, 0, 1'b1, 2'd2, 16'h0000);
      drive(16'h0000, 16'hFFFF, 16'h0000, 1, 0, 1'b1, 2'd2, 16'h0000);
      drive(16'h0000, 16'h0000, 16'h0000, 2, 0, 1'b1, 2'd2, 16'hFFFF);
      drive(16'h0000, 16'h0000, 16'h0000, 3, 0, 1'b1, 2'd2, 16'h0000);
      drive(16'hFFFF, 16'h0000, 16'hFFFF, 0, 1, 1'b1, 2'd2, 16'h0000);
      drive(16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 1, 1'b1, 2'd2, 16'h0000);
      drive(16'h0000, 16'h0000, 16'h0000, 2, 1, 1'b1, 2'd2, 16'hFFFF);
      drive(16'h0000, 16'h0000, 16'h0000, 0, 2, 1'b1, 2'd2, 16'h0000);
      drive(16'h0000, 16'h1064, 16'h0000, 1, 2, 1'b1, 2'd2, 16'h0000);
      drive(16'h0000, 16'h0000, 16'h0000, 2, 2, 1'b1, 2'd2, 16'h51F4);
      drive(16'h0000, 16'h0000, 16'h0000, 3, 2, 1'b1, 2'd2, 16'h0000);

      // Edge: 8x{2,3,4} = {16,24,32->31}.
      drive(16'h0000, 16'h0000, 16'h0000, 0, 0, 1'b1, 2'd3, 16'h0000);
      drive(16'h0000, 16'h1064, 16'h0000, 1, 0, 1'b1, 2'd3, 16'h0000);
      drive(16'h0000, 16'h0000, 16'h0000, 2, 0, 1'b1, 2'd3, 16'h831F);
      drive(16'h0000, 16'h0000, 16'h0000, 3, 0, 1'b1, 2'd3, 16'h0000);

      // Reset mid-stream: sharpen on a flat field reproduces the pixel.
      drive(16'h1234, 16'h1234, 16'h1234, 0, 0, 1'b1, 2'd2, 16'h1234);
      drive(16'h1234, 16'h1234, 16'h1234, 1, 0, 1'b1, 2'd2, 16'h1234);
      drive(16'h1234, 16'h1234, 16'h1234, 2, 0, 1'b1, 2'd2, 16'h1234);
      drive(16'h1234, 16'h1234, 16'h1234, 3, 0, 1'b1, 2'd2, 16'h1234);
      drive(16'h1234, 16'h1234, 16'h1234, 4, 0, 1'b1, 2'd2, 16'h1234);
      idle();
      found = 0;
      for (int i = 0; i < 10 && found == 0; i++) begin
         @(negedge clk_in);
         if (data_valid_out === 1'b1 && hcount_out == 11'd2) found = 1;
      end
      check("reset_setup_reached", found, 1);
      #2 rst_in = 1'b1;
      #1;
      check("midreset_line", line_out, 0);
      check("midreset_valid", data_valid_out, 0);
      check("midreset_hcount", hcount_out, 0);
      check("midreset_vcount", vcount_out, 0);
      check("midreset_kernel", kernel_active_out, 0);
      rst_in = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_in);
         #1;
         check("valid_low_after_reset", data_valid_out, 0);
      end

      // Valid gaps: invalid columns (with a stray kernel request) are ignored.
      drive(16'h0000, 16'h1111, 16'h0000, 0, 0, 1'b1, 2'd0, 16'h1111);
      drive(16'hDEAD, 16'hDEAD, 16'hDEAD, 0, 0, 1'b0, 2'd3, 16'h0000);
      drive(16'h0000, 16'h2222, 16'h0000, 1, 0, 1'b1, 2'd0, 16'h1111);
      drive(16'hDEAD, 16'hDEAD, 16'hDEAD, 0, 0, 1'b0, 2'd3, 16'h0000);
      drive(16'h0000, 16'h3333, 16'h0000, 2, 0, 1'b1, 2'd0, 16'h2222);
      drive(16'h0000, 16'h4444, 16'h0000, 3, 0, 1'b1, 2'd0, 16'h3333);
      idle();
      check("kernel_ignore_invalid", kernel_active_out, 0);

      repeat (6) idle();
      check("queue_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
